// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants one producer per bounded burst and throttles every beat on the FIFO full flag.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    localparam int GW = $clog2(NUM_REQ),
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic [NUM_REQ-1:0]            in_req_valid,
    input  logic [NUM_REQ-1:0]            in_req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_data,
    output logic [NUM_REQ-1:0]            out_req_ready,
    input  logic                          in_fifo_full,
    output logic                          out_fifo_wen,
    output logic [DATA_WIDTH-1:0]         out_fifo_wdata,
    output logic [GW-1:0]                 out_grant_id,
    output logic                          out_busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [BW-1:0] MAX_BEATS = BW'(MAX_BURST);

    state_t          state_r;
    logic [GW-1:0]   grant_r;
    logic [GW-1:0]   last_grant_r;
    logic [BW-1:0]   beat_cnt_r;

    logic [GW-1:0]   winner_s;
    logic            found_s;
    logic            busy_s;
    logic            accept_s;
    logic            burst_done_s;
    logic [BW-1:0]   beat_inc_s;
    logic [NUM_REQ-1:0] ready_s;

    // Round-robin search starting just after the last served producer, wrapping modulo NUM_REQ.
    always_comb begin
        logic [GW-1:0] idx_v;
        winner_s = '0;
        found_s  = 1'b0;
        idx_v    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v = GW'((int'(last_grant_r) + k) % NUM_REQ);
            if (!found_s && in_req_valid[idx_v]) begin
                found_s  = 1'b1;
                winner_s = idx_v;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Handshake decode for the granted producer; combinational so full throttles in the same cycle.
    always_comb begin
        busy_s       = (state_r == GRANT);
        accept_s     = busy_s && in_req_valid[grant_r] && !in_fifo_full;
        beat_inc_s   = beat_cnt_r + BW'(1);
        burst_done_s = in_req_last[grant_r] || (beat_inc_s == MAX_BEATS);
        ready_s      = '0;
        if (busy_s && !in_fifo_full) begin
            ready_s[grant_r] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Arbitration FSM: grant index, fairness pointer and beat counter.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= GW'(NUM_REQ - 1);
            beat_cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r      <= winner_s;
                        last_grant_r <= winner_s;
                        beat_cnt_r   <= '0;
                        state_r      <= GRANT;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                GRANT: begin
                    if (accept_s) begin
                        beat_cnt_r <= beat_inc_s;
                        if (burst_done_s) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= GRANT;
                        end
                    end else begin
                        state_r <= GRANT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign out_req_ready  = ready_s;
    assign out_fifo_wen   = accept_s;
    assign out_fifo_wdata = in_req_data[int'(grant_r) * DATA_WIDTH +: DATA_WIDTH];
    assign out_grant_id   = grant_r;
    assign out_busy       = busy_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues drive stimulus, a
// transaction-level model predicts outputs every cycle, and logs pin each scenario.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    in_req_valid = '0;
    logic [N-1:0]    in_req_last = '0;
    logic [N*DW-1:0] in_req_data = '0;
    logic [N-1:0]    out_req_ready;
    logic            in_fifo_full = 1'b0;
    logic            out_fifo_wen;
    logic [DW-1:0]   out_fifo_wdata;
    logic [1:0]      out_grant_id;
    logic            out_busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .in_clk(clk), .in_rst_n(rst_n),
        .in_req_valid(in_req_valid), .in_req_last(in_req_last), .in_req_data(in_req_data),
        .out_req_ready(out_req_ready), .in_fifo_full(in_fifo_full),
        .out_fifo_wen(out_fifo_wen), .out_fifo_wdata(out_fifo_wdata),
        .out_grant_id(out_grant_id), .out_busy(out_busy)
    );

    always #5 clk = ~clk;

    // Producer stimulus queues and directed overrides
    logic [31:0] qd [N][$];
    bit          ql [N][$];
    bit          gap [N];

    // Observed and expected transaction logs
    logic [31:0] wlog [$];
    int          glog [$];
    logic [31:0] exp_w [$];
    int          exp_g [$];
    bit          prev_busy = 1'b0;

    // Transaction-level model state
    bit m_busy  = 1'b0;
    int m_gid   = 0;
    int m_last  = N - 1;
    int m_beats = 0;
    int pick;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always_comb pick = rr_pick(m_last, in_req_valid);

    // Model: who owns the port, who was served last, beats taken in this grant
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_gid   <= 0;
            m_last  <= N - 1;
            m_beats <= 0;
        end else if (!m_busy) begin
            if (pick >= 0) begin
                m_busy  <= 1'b1;
                m_gid   <= pick;
                m_last  <= pick;
                m_beats <= 0;
            end
        end else if (in_req_valid[m_gid] && !in_fifo_full) begin
            m_beats <= m_beats + 1;
            if (in_req_last[m_gid] || (m_beats + 1 == MB)) m_busy <= 1'b0;
        end
    end

    // Per-cycle compare against the model, plus write/grant logging
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] e_rdy;
            e_rdy = '0;
            if (m_busy && !in_fifo_full) e_rdy[m_gid] = 1'b1;
            chk("ready", 64'(out_req_ready), 64'(e_rdy));
            chk("wen", 64'(out_fifo_wen), 64'(m_busy && in_req_valid[m_gid] && !in_fifo_full));
            chk("busy", 64'(out_busy), 64'(m_busy));
            chk("grant_id", 64'(out_grant_id), 64'(m_gid));
            chk("wdata", 64'(out_fifo_wdata), 64'(in_req_data[m_gid*DW +: DW]));
            if (out_fifo_wen) wlog.push_back(out_fifo_wdata);
            if (out_busy && !prev_busy) glog.push_back(int'(out_grant_id));
            prev_busy <= out_busy;
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_req_valid[i] = (qd[i].size() > 0) && !gap[i];
            in_req_last[i]  = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
            in_req_data[i*DW +: DW] = (qd[i].size() > 0) ? qd[i][0] : 32'h0;
        end
    endtask

    // One clock: note accepted beats mid-cycle, retire them after the edge, re-drive
    task automatic cycle();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = in_req_valid & out_req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        end
        drive();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (qd[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((pending() || out_busy) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic push(input int p, input logic [31:0] d, input bit l);
        qd[p].push_back(d);
        ql[p].push_back(l);
    endtask

    task automatic clear_logs();
        wlog.delete(); glog.delete(); exp_w.delete(); exp_g.delete();
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
            chk({tag, "_wdata"}, 64'(wlog[i]), 64'(exp_w[i]));
        chk({tag, "_ngrants"}, 64'(glog.size()), 64'(exp_g.size()));
        for (int i = 0; i < exp_g.size() && i < glog.size(); i++)
            chk({tag, "_grant"}, 64'(glog[i]), 64'(exp_g[i]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk_en = 1'b1;
        do_reset();
        chk("rst_busy", 64'(out_busy), 64'(0));
        chk("rst_gid", 64'(out_grant_id), 64'(0));
        chk("rst_ready", 64'(out_req_ready), 64'(0));
        chk("rst_wen", 64'(out_fifo_wen), 64'(0));

        // Single producer: 3 beats from producer 2
        clear_logs();
        push(2, 32'hA, 1'b0); push(2, 32'hB, 1'b0); push(2, 32'hC, 1'b1);
        drive();
        cycle();
        chk("single_busy", 64'(out_busy), 64'(1));
        chk("single_gid", 64'(out_grant_id), 64'(2));
        chk("single_ready", 64'(out_req_ready), 64'(4'b0100));
        chk("single_wdata", 64'(out_fifo_wdata), 64'(32'hA));
        wait_idle("single", 20);
        exp_w = '{32'hA, 32'hB, 32'hC};
        exp_g = '{2};
        check_logs("single");

        // Round-robin: all producers, single-beat bursts, fresh reset
        do_reset();
        clear_logs();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++) push(i, 32'h200 + 32'(16 * i + j), 1'b1);
        drive();
        wait_idle("rr", 60);
        exp_w = '{32'h200, 32'h210, 32'h220, 32'h230, 32'h201, 32'h211, 32'h221, 32'h231};
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_logs("rr");

        // Burst cap: producer 1 streams 12 beats with last never set
        clear_logs();
        for (int k = 0; k < 12; k++) push(1, 32'h300 + 32'(k), 1'b0);
        drive();
        cycle();
        push(3, 32'h330, 1'b1);
        push(0, 32'h3F0, 1'b1);
        drive();
        wait_idle("cap", 80);
        exp_w = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h330, 32'h3F0,
                  32'h304, 32'h305, 32'h306, 32'h307, 32'h308, 32'h309, 32'h30A, 32'h30B};
        exp_g = '{1, 3, 0, 1, 1};
        check_logs("cap");

        // Full backpressure for 3 cycles mid-burst
        clear_logs();
        for (int k = 0; k < 4; k++) push(2, 32'h400 + 32'(k), 1'b0);
        drive();
        cycle();
        cycle();
        cycle();
        in_fifo_full = 1'b1;
        drive();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("full_wen", 64'(out_fifo_wen), 64'(0));
            chk("full_ready", 64'(out_req_ready), 64'(0));
            chk("full_busy", 64'(out_busy), 64'(1));
            cycle();
            if (k == 2) begin
                in_fifo_full = 1'b0;
                drive();
            end
        end
        wait_idle("full", 30);
        exp_w = '{32'h400, 32'h401, 32'h402, 32'h403};
        exp_g = '{2};
        check_logs("full");

        // Valid gap: producer 3 drops valid for 2 cycles while producer 0 waits
        clear_logs();
        push(3, 32'h500, 1'b0); push(3, 32'h501, 1'b0); push(3, 32'h502, 1'b1);
        push(0, 32'h600, 1'b1);
        drive();
        cycle();
        cycle();
        gap[3] = 1'b1;
        drive();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("gap_busy", 64'(out_busy), 64'(1));
            chk("gap_gid", 64'(out_grant_id), 64'(3));
            chk("gap_wen", 64'(out_fifo_wen), 64'(0));
            chk("gap_others", 64'(out_req_ready & 4'b0111), 64'(0));
            cycle();
        end
        gap[3] = 1'b0;
        drive();
        wait_idle("gap", 30);
        exp_w = '{32'h500, 32'h501, 32'h502, 32'h600};
        exp_g = '{3, 0};
        check_logs("gap");

        // Async reset during beat 2 of a producer-3 burst
        clear_logs();
        for (int k = 0; k < 4; k++) push(3, 32'h700 + 32'(k), k == 3);
        drive();
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wen", 64'(out_fifo_wen), 64'(0));
        chk("arst_ready", 64'(out_req_ready), 64'(0));
        chk("arst_busy", 64'(out_busy), 64'(0));
        chk("arst_gid", 64'(out_grant_id), 64'(0));
        for (int i = 0; i < N; i++) begin
            qd[i].delete();
            ql[i].delete();
            push(i, 32'h800 + 32'(i), 1'b1);
        end
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("arst", 40);
        exp_w = '{32'h700, 32'h800, 32'h801, 32'h802, 32'h803};
        exp_g = '{3, 0, 1, 2, 3};
        check_logs("arst");

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
